// File: rtl/motor_cmd_sequencer.sv
// Turns the one-hot motor_state command into 4-byte UART frames (AA, cmd, spd, chk)
// and streams them byte by byte over a valid/ready link, with change- and heartbeat-triggered sends.
module motor_cmd_sequencer #(
    parameter logic [7:0]  SPEED          = 8'h40,
    parameter logic [31:0] REFRESH_CYCLES = 32'd5_000_000,
    parameter logic [7:0]  GAP_CYCLES     = 8'd16
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [4:0] motor_state,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy,
    output logic [2:0] last_cmd
);

    localparam logic [7:0] HEADER = 8'hAA;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        CMD  = 3'd2,
        SPD  = 3'd3,
        CHK  = 3'd4,
        GAP  = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [2:0]  dec_cmd;
    logic [2:0]  frame_cmd;
    logic [7:0]  frame_spd;
    logic [2:0]  sent_cmd;
    logic        sent_valid;
    logic [31:0] refresh_cnt;
    logic [7:0]  gap_cnt;

    logic        refresh_due;
    logic        trigger;
    logic        start_frame;
    logic        frame_done;

    // Anything that is not exactly one-hot falls back to stop.
    function automatic logic [2:0] decode_cmd(input logic [4:0] ms);
        logic [2:0] c;
        case (ms)
            5'b00001: c = 3'd0;
            5'b00010: c = 3'd1;
            5'b00100: c = 3'd2;
            5'b01000: c = 3'd3;
            5'b10000: c = 3'd4;
            default:  c = 3'd0;
        endcase
        return c;
    endfunction

    function automatic logic [7:0] speed_for(input logic [2:0] cmd);
        return (cmd == 3'd0) ? 8'h00 : SPEED;
    endfunction

    function automatic logic [7:0] frame_chk(input logic [2:0] cmd, input logic [7:0] spd);
        return HEADER ^ {5'b00000, cmd} ^ spd;
    endfunction

    assign dec_cmd     = decode_cmd(motor_state);
    assign refresh_due = (refresh_cnt == (REFRESH_CYCLES - 32'd1));
    assign trigger     = !sent_valid || (dec_cmd != sent_cmd) || refresh_due;
    assign start_frame = (state == IDLE) && trigger;
    assign frame_done  = (state == CHK) && tx_ready;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (trigger) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = HEADER;
                if (tx_ready) begin
                    state_next = CMD;
                end
            end
            CMD: begin
                tx_valid = 1'b1;
                tx_data  = {5'b00000, frame_cmd};
                if (tx_ready) begin
                    state_next = SPD;
                end
            end
            SPD: begin
                tx_valid = 1'b1;
                tx_data  = frame_spd;
                if (tx_ready) begin
                    state_next = CHK;
                end
            end
            CHK: begin
                tx_valid = 1'b1;
                tx_data  = frame_chk(frame_cmd, frame_spd);
                if (tx_ready) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == (GAP_CYCLES - 8'd1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control state: sent-command tracking, heartbeat and inter-frame gap counters.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sent_valid  <= 1'b0;
            sent_cmd    <= 3'd0;
            last_cmd    <= 3'd0;
            refresh_cnt <= 32'd0;
            gap_cnt     <= 8'd0;
        end else begin
            if (start_frame) begin
                refresh_cnt <= 32'd0;
            end else if (!refresh_due) begin
                refresh_cnt <= refresh_cnt + 32'd1;
            end

            if (frame_done) begin
                sent_cmd   <= frame_cmd;
                sent_valid <= 1'b1;
                last_cmd   <= frame_cmd;
                gap_cnt    <= 8'd0;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + 8'd1;
            end
        end
    end

    // Frame snapshot is pure data; it is only read in byte states entered after a load.
    always_ff @(posedge CLOCK_50) begin
        if (start_frame) begin
            frame_cmd <= dec_cmd;
            frame_spd <= speed_for(dec_cmd);
        end
    end

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Directed bench for motor_cmd_sequencer: reset/latency, heartbeat, stalls,
// mid-frame command changes, a decode table and reset during a frame.
module tb_motor_cmd_sequencer;

    logic       clk;
    logic       reset;
    logic [4:0] motor_state;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       busy;
    logic [2:0] last_cmd;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    motor_cmd_sequencer #(
        .SPEED(8'h40),
        .REFRESH_CYCLES(32'd200),
        .GAP_CYCLES(8'd4)
    ) dut (
        .CLOCK_50(clk),
        .reset(reset),
        .motor_state(motor_state),
        .tx_ready(tx_ready),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .busy(busy),
        .last_cmd(last_cmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [4:0]  ms;
        logic [2:0]  cmd;
        logic [31:0] frame;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            tick();
        end
        check("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    // Collects one frame with tx_ready held high; returns after the CHK acceptance edge.
    task automatic capture(output logic [31:0] frame, output int start, output bit ok);
        int n;
        n     = 0;
        frame = 32'd0;
        start = -1;
        tx_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (tx_valid) begin
                if (n == 0) start = cyc;
                frame = {frame[23:0], tx_data};
                n++;
            end
            tick();
            if (n == 4) break;
        end
        ok = (n == 4);
    endtask

    logic [31:0] fr;
    int          s1, s2, s3;
    bit          ok;
    int          idx, hold_err, valid_cnt;
    logic [31:0] exp_bytes;

    initial begin
        vecs[0] = '{ms: 5'b00001, cmd: 3'd0, frame: 32'hAA0000AA};
        vecs[1] = '{ms: 5'b00000, cmd: 3'd0, frame: 32'hAA0000AA};
        vecs[2] = '{ms: 5'b00110, cmd: 3'd0, frame: 32'hAA0000AA};
        vecs[3] = '{ms: 5'b11000, cmd: 3'd0, frame: 32'hAA0000AA};
        vecs[4] = '{ms: 5'b00010, cmd: 3'd1, frame: 32'hAA0140EB};
        vecs[5] = '{ms: 5'b00100, cmd: 3'd2, frame: 32'hAA0240E8};
        vecs[6] = '{ms: 5'b01000, cmd: 3'd3, frame: 32'hAA0340E9};
        vecs[7] = '{ms: 5'b10000, cmd: 3'd4, frame: 32'hAA0440EE};

        reset       = 1'b1;
        motor_state = 5'b10000;
        tx_ready    = 1'b1;
        tick(); tick(); tick();
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_last_cmd", {29'd0, last_cmd}, 32'd0);

        // Spin frame right after release, back-to-back bytes, then the gap.
        reset = 1'b0;
        tick(); check("spin_b0", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hAA});
        tick(); check("spin_b1", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h04});
        tick(); check("spin_b2", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h40});
        tick(); check("spin_b3", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hEE});
        tick();
        check("spin_gap_valid", {31'd0, tx_valid}, 32'd0);
        check("spin_last_cmd", {29'd0, last_cmd}, 32'd4);
        check("spin_gap_busy0", {31'd0, busy}, 32'd1);
        for (int k = 1; k < 4; k++) begin
            tick();
            check("spin_gap_busy", {31'd0, busy}, 32'd1);
        end
        tick();
        check("spin_idle_busy", {31'd0, busy}, 32'd0);

        // Heartbeat: forward frame repeats every 200 cycles start to start.
        motor_state = 5'b00010;
        capture(fr, s1, ok);
        check("hb_ok1", {31'd0, ok}, 32'd1);
        check("hb_frame1", fr, 32'hAA0140EB);
        capture(fr, s2, ok);
        check("hb_ok2", {31'd0, ok}, 32'd1);
        check("hb_frame2", fr, 32'hAA0140EB);
        capture(fr, s3, ok);
        check("hb_ok3", {31'd0, ok}, 32'd1);
        check("hb_frame3", fr, 32'hAA0140EB);
        check("hb_period1", s2 - s1, 32'd200);
        check("hb_period2", s3 - s2, 32'd200);

        // Stalled link: tx_ready high one cycle in four.
        wait_idle();
        motor_state = 5'b01000;
        tx_ready    = 1'b0;
        exp_bytes   = 32'hAA0340E9;
        idx = 0; hold_err = 0; valid_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            tx_ready = ((i % 4) == 3);
            if (tx_valid) begin
                valid_cnt++;
                if (tx_data !== exp_bytes[31 - 8*idx -: 8]) hold_err++;
                if (tx_ready) idx++;
            end else if (idx > 0) begin
                hold_err++;
            end
            if (idx == 4) break;
        end
        tick();
        check("stall_bytes_done", idx, 32'd4);
        check("stall_hold_err", hold_err, 32'd0);
        check("stall_valid_cnt", valid_cnt, 32'd16);
        check("stall_last_cmd", {29'd0, last_cmd}, 32'd3);

        // Command changes during SPD and during GAP.
        tx_ready = 1'b1;
        wait_idle();
        motor_state = 5'b00010;
        tick(); check("chg_b0", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hAA});
        tick(); check("chg_b1", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h01});
        tick(); check("chg_b2", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h40});
        motor_state = 5'b01000;
        tick(); check("chg_b3", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hEB});
        tick();
        check("chg_gap_valid", {31'd0, tx_valid}, 32'd0);
        check("chg_last_cmd1", {29'd0, last_cmd}, 32'd1);
        motor_state = 5'b00100;
        capture(fr, s1, ok);
        check("chg_ok", {31'd0, ok}, 32'd1);
        check("chg_next_frame", fr, 32'hAA0240E8);
        check("chg_last_cmd2", {29'd0, last_cmd}, 32'd2);

        // Decode table.
        for (int v = 0; v < 8; v++) begin
            wait_idle();
            motor_state = vecs[v].ms;
            capture(fr, s1, ok);
            check($sformatf("vec%0d_ok", v), {31'd0, ok}, 32'd1);
            check($sformatf("vec%0d_frame", v), fr, vecs[v].frame);
            check($sformatf("vec%0d_last_cmd", v), {29'd0, last_cmd}, {29'd0, vecs[v].cmd});
        end

        // Reset while the CMD byte is pending.
        wait_idle();
        motor_state = 5'b00010;
        tx_ready    = 1'b1;
        tick(); check("rmid_b0", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hAA});
        tick(); check("rmid_b1", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h01});
        tx_ready    = 1'b0;
        reset       = 1'b1;
        motor_state = 5'b00001;
        tick();
        check("rmid_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rmid_busy", {31'd0, busy}, 32'd0);
        check("rmid_last_cmd", {29'd0, last_cmd}, 32'd0);
        reset = 1'b0;
        capture(fr, s1, ok);
        check("rmid_ok", {31'd0, ok}, 32'd1);
        check("rmid_frame", fr, 32'hAA0000AA);
        check("rmid_last_cmd2", {29'd0, last_cmd}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
